// File: rtl/spi_rx_apb_slave.sv
// SPI mode-0 receiver with an APB-mapped receive FIFO, status/control
// registers and a registered interrupt request.
module spi_rx_apb_slave #(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       psel,
    input  logic       penable,
    input  logic       pwrite,
    input  logic [7:0] paddr,
    input  logic [7:0] pwdata,
    output logic [7:0] prdata,
    output logic       pready,
    output logic       pslverr,
    input  logic       sclk,
    input  logic       mosi,
    input  logic       cs_n,
    output logic       irq
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    // Synchronizers and edge-detect history
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   cs_prev_q,   cs_prev_d;
    logic [SYNC_STAGES:0]   fill_q,      fill_d;
    logic                   active_q,    active_d;

    // Receive datapath
    logic [2:0]      bit_cnt_q,   bit_cnt_d;
    logic [7:0]      shift_q,     shift_d;
    logic            push_q,      push_d;
    logic [7:0]      push_data_q, push_data_d;

    // FIFO
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q,  count_d;

    // Registers
    logic            en_q,     en_d;
    logic [2:0]      int_en_q, int_en_d;
    logic            ovf_q,    ovf_d;
    logic            ferr_q,   ferr_d;
    logic            irq_q,    irq_d;
    logic            pready_q, pready_d;

    logic sclk_s, mosi_s, cs_s, sync_valid, sclk_rise, cs_rise;
    logic access, xfer, addr_bad, acc_err, wr_ok, rd_ok;
    logic pop, flush, do_push, do_pop, ovf_set, ferr_set;
    logic empty, full;
    logic [4:0] count_ext;
    logic [7:0] status, rdata;

    assign sclk_s     = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s     = mosi_sync_q[SYNC_STAGES-1];
    assign cs_s       = cs_sync_q[SYNC_STAGES-1];
    assign sync_valid = fill_q[SYNC_STAGES];
    assign sclk_rise  = sclk_s & ~sclk_prev_q;
    assign cs_rise    = cs_s & ~cs_prev_q;

    assign empty     = (count_q == '0);
    assign full      = (count_q == DEPTH_C);
    assign count_ext = 5'(count_q);
    assign status    = {ferr_q, ovf_q, count_ext[3:0], full, empty};

    assign access   = psel & penable;
    assign xfer     = access & pready_q;
    assign addr_bad = (paddr > 8'h03);
    assign acc_err  = addr_bad | (pwrite & (paddr == 8'h00));
    assign wr_ok    = xfer & pwrite & ~acc_err;
    assign rd_ok    = xfer & ~pwrite & ~acc_err;
    assign pop      = rd_ok & (paddr == 8'h00) & ~empty;
    assign flush    = wr_ok & (paddr == 8'h02) & pwdata[1];

    assign pready = pready_q;
    assign irq    = irq_q;

    always_comb begin
        rdata = '0;
        unique case (paddr[1:0])
            2'd0: rdata = empty ? 8'h00 : mem_q[rd_ptr_q];
            2'd1: rdata = status;
            2'd2: rdata = {7'b0, en_q};
            2'd3: rdata = {5'b0, int_en_q};
            default: rdata = '0;
        endcase
        prdata  = (pready_q && !pwrite && !acc_err) ? rdata : 8'h00;
        pslverr = pready_q & acc_err;
    end

    always_comb begin
        sclk_sync_d[0] = sclk;
        mosi_sync_d[0] = mosi;
        cs_sync_d[0]   = cs_n;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sclk_sync_d[i] = sclk_sync_q[i-1];
            mosi_sync_d[i] = mosi_sync_q[i-1];
            cs_sync_d[i]   = cs_sync_q[i-1];
        end
        sclk_prev_d = sclk_s;
        cs_prev_d   = cs_s;
        fill_d      = {fill_q[SYNC_STAGES-1:0], 1'b1};

        // A frame only opens on a falling edge seen once the synchronizers
        // hold real samples, so cs_n held low across reset never counts.
        active_d = active_q;
        if (cs_s)
            active_d = 1'b0;
        else if (sync_valid && cs_prev_q)
            active_d = 1'b1;

        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        push_d      = 1'b0;
        push_data_d = push_data_q;
        ferr_set    = 1'b0;
        if (!en_q || cs_s) begin
            bit_cnt_d = '0;
            ferr_set  = en_q & cs_rise & (bit_cnt_q != 3'd0);
        end else if (active_q && sclk_rise) begin
            shift_d = {shift_q[6:0], mosi_s};
            if (bit_cnt_q == 3'd7) begin
                push_d      = 1'b1;
                push_data_d = {shift_q[6:0], mosi_s};
                bit_cnt_d   = '0;
            end else begin
                bit_cnt_d = bit_cnt_q + 3'd1;
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = 1'b0;
        do_pop   = 1'b0;
        ovf_set  = 1'b0;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            do_pop  = pop;
            do_push = push_q & (~full | pop);
            ovf_set = push_q & full & ~pop;
            if (do_push)
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_pop)
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end

        en_d     = en_q;
        int_en_d = int_en_q;
        ovf_d    = ovf_q;
        ferr_d   = ferr_q;
        if (wr_ok && paddr == 8'h01) begin
            if (pwdata[6]) ovf_d  = 1'b0;
            if (pwdata[7]) ferr_d = 1'b0;
        end
        if (wr_ok && paddr == 8'h02)
            en_d = pwdata[0];
        if (wr_ok && paddr == 8'h03)
            int_en_d = pwdata[2:0];
        if (ovf_set)  ovf_d  = 1'b1;
        if (ferr_set) ferr_d = 1'b1;

        irq_d    = (int_en_q[0] & ~empty) | (int_en_q[1] & ovf_q) | (int_en_q[2] & ferr_q);
        pready_d = access & ~pready_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            cs_sync_q   <= '1;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            fill_q      <= '0;
            active_q    <= 1'b0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            en_q        <= 1'b0;
            int_en_q    <= '0;
            ovf_q       <= 1'b0;
            ferr_q      <= 1'b0;
            irq_q       <= 1'b0;
            pready_q    <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            cs_sync_q   <= cs_sync_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
            fill_q      <= fill_d;
            active_q    <= active_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            en_q        <= en_d;
            int_en_q    <= int_en_d;
            ovf_q       <= ovf_d;
            ferr_q      <= ferr_d;
            irq_q       <= irq_d;
            pready_q    <= pready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem_q[wr_ptr_q] <= push_data_q;
    end

endmodule
